operand_stage: RTL and testbench
================================

# operand_stage

Parametrised operand-select stage feeding the ALU. Decodes immediates from the instruction payload, selects ALU operands A and B, and bypasses register reads from up to NFWD later pipeline stages. Adds a valid/ready handshake with a 2-entry skid buffer so back-pressure from the ALU never drops an operand pair. Sits between register read and the ALU.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- NFWD, 2, number of forwarding sources; index 0 has the highest priority.
- TAG_W, 30, width of the side-band tag (PC word address) passed through unchanged.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- a_sel  in  2  operand A select: 0 UP, 1 JT, 2 BT, 3 REGA.
- b_sel  in  3  operand B select: 0 LI, 1 ST, 2 PC, 3 RS2, 4 REGB, 5–7 ZERO.
- inst_data  in  25  instruction bits [31:7]; inst_data[k] = instr[k+7].
- pc  in  TAG_W  PC word address; also used as the tag.
- reg_a, reg_b  in  XLEN each  register file read data for rs1 and rs2.
- fwd_valid  in  NFWD  forwarding entry valid.
- fwd_rd  in  5*NFWD  destination register of each entry.
- fwd_data  in  XLEN*NFWD  result of each entry.
- out_valid  out  1  operand pair valid.
- out_ready  in  1  ALU accepts the pair.
- out_a, out_b  out  XLEN each  selected operands.
- out_tag  out  TAG_W  PC tag of the pair.

## Operation
- Register fields: rs1 = instr[19:15], rs2 = instr[24:20].
- Immediates, each sign-extended to XLEN:
  - UP = {instr[31:12], 12'b0}; for XLEN=64, sign-extend the 32-bit value.
  - LI = instr[31:20].
  - ST = {instr[31:25], instr[11:7]}.
  - BT = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - JT = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- PC operand = {pc, 2'b0}, zero-extended or truncated to XLEN.
- RS2 operand = zero-extended rs2 (shift amount).
- Forwarding applies to REGA (rs1) and REGB (rs2) only:
  - The lowest index i with fwd_valid[i] and fwd_rd[i] equal to the source register, and that register nonzero, wins and supplies fwd_data[i].
  - Otherwise reg_a / reg_b is used.
  - Register x0 is never forwarded; reg_a / reg_b is used as-is.
- Operands are computed combinationally in the accept cycle and captured. Forwarding inputs are not re-sampled later.
- Storage is an output register OUT plus a skid register SKD (each holds a, b, tag). State machine:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with out_ready=1: new beat replaces OUT; stay ONE.
    - Accept with out_ready=0: beat goes into SKD → FULL.
    - No accept with out_ready=1 → EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - out_ready=1: SKD moves to OUT → ONE.
- Accept = in_valid && in_ready. Inputs are ignored when in_ready=0.
- flush: next state is EMPTY regardless of other inputs. Flush overrides a same-cycle accept, whose beat is dropped. Data registers are not cleared.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_tag=0, state EMPTY, in_ready=1 (in_ready is registered/state-derived, not combinational from out_ready).
- Latency: a beat accepted at edge N appears on out_* with out_valid=1 after edge N; one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Order is strictly preserved; no beat is duplicated or dropped except by flush or rst.
- out_* are stable while out_valid=1 and out_ready=0.
- rst asserted mid-operation clears state immediately (asynchronously), and both entries are lost.

## Test plan
- Reset, then beat with a_sel=UP, b_sel=LI, instr=0xFFF00093, out_ready=1 → after 1 cycle: out_a=0xFFF00000, out_b=0xFFFFFFFF, out_valid=1.
- a_sel=REGA, b_sel=REGB, rs1=5, rs2=0, reg_a=1, reg_b=2; fwd_valid=2'b11, fwd_rd={5,5}, fwd_data={0xBB,0xAA} → out_a=0xAA (index 0 wins), out_b=2 (x0 not forwarded).
- out_ready=0, three back-to-back beats T1, T2, T3 → T1 in OUT, T2 in SKD, in_ready=0, T3 held off. Raise out_ready → order T1, T2, T3 with no loss.
- b_sel=PC, pc=0x3FFFFFFF → out_b=0xFFFFFFFC. b_sel=RS2 with rs2=31 → out_b=31. b_sel=6 → out_b=0.
- State FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed beat never appears.
- XLEN=64, JT with instr[31]=1 → upper 44 bits of out_a all ones. Assert rst mid-stream → out_valid drops to 0 immediately.

Source files
------------

// File: rtl/operand_stage.sv
// operand_stage: operand-select stage in front of the ALU.
// Decodes the instruction immediates, selects operands A and B, bypasses
// register reads from NFWD later pipeline stages (index 0 highest priority),
// and holds up to two operand pairs behind a valid/ready handshake so ALU
// back-pressure never loses a pair.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous discard of all held pairs
//   in_valid/in_ready input handshake (in_ready is state-derived)
//   a_sel             0 UP, 1 JT, 2 BT, 3 REGA
//   b_sel             0 LI, 1 ST, 2 PC, 3 RS2, 4 REGB, 5-7 ZERO
//   inst_data         instruction bits [31:7]
//   pc                PC word address, also passed through as the tag
//   reg_a, reg_b      register file read data for rs1 / rs2
//   fwd_valid/rd/data forwarding entries, packed index 0 in the LSBs
//   out_valid/ready   output handshake
//   out_a, out_b      selected operands
//   out_tag           PC tag of the pair
module operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned TAG_W = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           a_sel,
  input  logic [2:0]           b_sel,
  input  logic [24:0]          inst_data,
  input  logic [TAG_W-1:0]     pc,
  input  logic [XLEN-1:0]      reg_a,
  input  logic [XLEN-1:0]      reg_b,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_a,
  output logic [XLEN-1:0]      out_b,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  // Bit numbering matches the full instruction word, so instr[k] is bit k.
  logic [31:7]      instr;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [31:0]      up32;
  logic [XLEN-1:0]  imm_up, imm_li, imm_st, imm_bt, imm_jt, pc_op, rs2_op;
  logic [XLEN-1:0]  src_a, src_b;
  beat_t            new_beat;
  beat_t            out_q, skd_q;
  state_t           state;
  logic             accept;

  assign instr = inst_data;
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

  // Immediate decode; size casts of signed values sign-extend to XLEN.
  assign up32   = {instr[31:12], 12'b0};
  assign imm_up = XLEN'($signed(up32));
  assign imm_li = XLEN'($signed(instr[31:20]));
  assign imm_st = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_bt = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_jt = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign pc_op  = XLEN'({pc, 2'b00});
  assign rs2_op = XLEN'(rs2);

  // Bypass: scan from the lowest-priority entry up so index 0 wins last.
  always_comb begin
    src_a = reg_a;
    src_b = reg_b;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[REG_W*i +: REG_W] == rs1) && (rs1 != '0)) begin
        src_a = fwd_data[XLEN*i +: XLEN];
      end
      if (fwd_valid[i] && (fwd_rd[REG_W*i +: REG_W] == rs2) && (rs2 != '0)) begin
        src_b = fwd_data[XLEN*i +: XLEN];
      end
    end
  end

  // Operand selection for the beat presented this cycle.
  always_comb begin
    new_beat     = '0;
    new_beat.tag = pc;
    case (a_sel)
      2'd0:    new_beat.a = imm_up;
      2'd1:    new_beat.a = imm_jt;
      2'd2:    new_beat.a = imm_bt;
      default: new_beat.a = src_a;
    endcase
    case (b_sel)
      3'd0:    new_beat.b = imm_li;
      3'd1:    new_beat.b = imm_st;
      3'd2:    new_beat.b = pc_op;
      3'd3:    new_beat.b = rs2_op;
      3'd4:    new_beat.b = src_b;
      default: new_beat.b = '0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Output register plus skid register; flush only resets control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skd_q     <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_q     <= new_beat;
            state     <= S_ONE;
            out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && out_ready) begin
            out_q <= new_beat;
          end else if (accept) begin
            skd_q    <= new_beat;
            state    <= S_FULL;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            out_q    <= skd_q;
            state    <= S_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_a   = out_q.a;
  assign out_b   = out_q.b;
  assign out_tag = out_q.tag;

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: table-driven vectors with a scoreboard for operand_stage,
// plus sequences for back-pressure, flush, async reset and XLEN=64 decode.
module tb_operand_stage;

  typedef struct {
    logic [1:0]  a_sel;
    logic [2:0]  b_sel;
    logic [31:0] instr;
    logic [29:0] pc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  fv;
    logic [9:0]  frd;
    logic [63:0] fd;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [29:0] tag;
  } exp_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [1:0]  a_sel;
  logic [2:0]  b_sel;
  logic [24:0] inst_data;
  logic [29:0] pc;
  logic [31:0] reg_a, reg_b, out_a, out_b;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic [29:0] out_tag, out64_tag;
  logic [63:0] reg_a64, reg_b64, out64_a, out64_b;
  logic [127:0] fwd_data64;
  logic [31:0] cur_ea, cur_eb;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[10];
  vec_t t;

  operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_sel(a_sel), .b_sel(b_sel), .inst_data(inst_data), .pc(pc),
    .reg_a(reg_a), .reg_b(reg_b), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
  );

  operand_stage #(.XLEN(64), .NFWD(2), .TAG_W(30)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .a_sel(a_sel), .b_sel(b_sel), .inst_data(inst_data), .pc(pc),
    .reg_a(reg_a64), .reg_b(reg_b64), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_a(out64_a), .out_b(out64_b), .out_tag(out64_tag)
  );

  assign reg_a64    = {32'h0, reg_a};
  assign reg_b64    = {32'h0, reg_b};
  assign fwd_data64 = {32'h0, fwd_data[63:32], 32'h0, fwd_data[31:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic iv);
    a_sel     = v.a_sel;
    b_sel     = v.b_sel;
    inst_data = v.instr[31:7];
    pc        = v.pc;
    reg_a     = v.ra;
    reg_b     = v.rb;
    fwd_valid = v.fv;
    fwd_rd    = v.frd;
    fwd_data  = v.fd;
    cur_ea    = v.ea;
    cur_eb    = v.eb;
    in_valid  = iv;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: inputs and outputs are stable mid-cycle, so decide here what
  // the coming edge transfers: pop on an output handshake, push on an accept.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got tag %h expected no output", out_tag);
        end else begin
          e = sb.pop_front();
          check("sb_a", 64'(out_a), 64'(e.a));
          check("sb_b", 64'(out_b), 64'(e.b));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) sb.push_back('{a: cur_ea, b: cur_eb, tag: pc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            a     b     instr         pc         ra      rb      fv     frd                fd                            ea            eb
    vecs[0] = '{2'd0, 3'd0, 32'hFFF00093, 30'h100,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'hFFF00000, 32'hFFFFFFFF};
    vecs[1] = '{2'd3, 3'd4, 32'h00028000, 30'h101,  32'h1,  32'h2,  2'b11, {5'd5, 5'd5},      {32'hBB, 32'hAA},             32'h000000AA, 32'h00000002};
    vecs[2] = '{2'd0, 3'd2, 32'h01F00000, 30'h3FFFFFFF, 32'h0, 32'h0, 2'b00, 10'd0,          64'h0,                        32'h01F00000, 32'hFFFFFFFC};
    vecs[3] = '{2'd2, 3'd3, 32'h01F00000, 30'h103,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'h00000000, 32'h0000001F};
    vecs[4] = '{2'd1, 3'd6, 32'h80000000, 30'h104,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'hFFF00000, 32'h00000000};
    vecs[5] = '{2'd2, 3'd1, 32'h80000080, 30'h105,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'hFFFFF800, 32'hFFFFF801};
    vecs[6] = '{2'd3, 3'd4, 32'h00728000, 30'h106,  32'h11, 32'h22, 2'b10, {5'd7, 5'd5},      {32'hBB, 32'hAA},             32'h00000011, 32'h000000BB};
    vecs[7] = '{2'd3, 3'd4, 32'h00000000, 30'h107,  32'h33, 32'h44, 2'b11, 10'd0,             {32'hBB, 32'hAA},             32'h00000033, 32'h00000044};
    vecs[8] = '{2'd0, 3'd0, 32'h12300000, 30'h108,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'h12300000, 32'h00000123};
    vecs[9] = '{2'd1, 3'd5, 32'h7FFFF000, 30'h109,  32'h0,  32'h0,  2'b00, 10'd0,             64'h0,                        32'h000FFFFE, 32'h00000000};

    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    apply(vecs[0], 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready64", 64'(in_ready64), 64'd1);
    tick();

    // Table: one beat per cycle with the ALU always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], 1'b1);
      tick();
      check("lat_out_valid", 64'(out_valid), 64'd1);
      check("lat_out_tag", 64'(out_tag), 64'(vecs[i].pc));
      if (i == 0) begin
        check("x64_up_a", out64_a, 64'hFFFFFFFF_FFF00000);
        check("x64_tag", 64'(out64_tag), 64'h100);
      end
      if (i == 2) check("x64_pc_b", out64_b, 64'h00000000_FFFFFFFC);
      if (i == 4) begin
        check("x64_jt_a", out64_a, 64'hFFFFFFFF_FFF00000);
        check("x64_jt_upper", 64'(out64_a[63:20]), 64'hFFF_FFFF_FFFF);
      end
      if (i == 5) check("x64_st_b", out64_b, 64'hFFFFFFFF_FFFFF801);
    end
    apply(vecs[0], 1'b0);
    tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: T1 in OUT, T2 in SKD, T3 held off until space frees.
    out_ready = 1'b0;
    t = vecs[0]; t.pc = 30'h200; apply(t, 1'b1); tick();
    t = vecs[5]; t.pc = 30'h201; apply(t, 1'b1); tick();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    t = vecs[6]; t.pc = 30'h202; apply(t, 1'b1);
    repeat (2) tick();
    check("hold_a", 64'(out_a), 64'hFFF00000);
    check("hold_tag", 64'(out_tag), 64'h200);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("skid_tag", 64'(out_tag), 64'h201);
    tick();
    check("t3_tag", 64'(out_tag), 64'h202);
    apply(vecs[0], 1'b0);
    tick();
    check("bp_out_valid", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in FULL with a beat offered alongside.
    out_ready = 1'b0;
    t = vecs[1]; t.pc = 30'h300; apply(t, 1'b1); tick();
    t = vecs[8]; t.pc = 30'h301; apply(t, 1'b1); tick();
    t = vecs[3]; t.pc = 30'h302; apply(t, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    apply(vecs[0], 1'b0);
    check("flush_full_valid", 64'(out_valid), 64'd0);
    check("flush_full_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_gone", 64'(out_valid), 64'd0);
    end

    // Flush in ONE overrides a same-cycle accept.
    out_ready = 1'b0;
    t = vecs[2]; t.pc = 30'h310; apply(t, 1'b1); tick();
    t = vecs[4]; t.pc = 30'h311; apply(t, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    apply(vecs[0], 1'b0);
    check("flush_one_valid", 64'(out_valid), 64'd0);
    check("flush_one_ready", 64'(in_ready), 64'd1);
    tick();
    check("flush_one_gone", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    t = vecs[9]; t.pc = 30'h312; apply(t, 1'b1); tick();
    check("post_flush_tag", 64'(out_tag), 64'h312);
    apply(vecs[0], 1'b0);
    tick();

    // Asynchronous reset in the middle of a held beat.
    out_ready = 1'b0;
    t = vecs[7]; t.pc = 30'h320; apply(t, 1'b1); tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    apply(vecs[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    check("async_rst_a", 64'(out_a), 64'd0);
    check("async_rst_valid64", 64'(out_valid64), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    t = vecs[8]; t.pc = 30'h330; apply(t, 1'b1); tick();
    check("post_rst_tag", 64'(out_tag), 64'h330);
    apply(vecs[0], 1'b0);
    tick();
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
